serial_tx_arbiter: RTL
======================

// Module: serial_tx_arbiter
// PURPOSE
//  Shares one serial transmitter datapath (one-pulser-free clkEn input, sequence
//  detector, SSD) between two parallel requesters. Grants one requester at a
//  time, round-robin, and serializes its frame (header, 4-bit count, payload)
//  onto serIn with paced single-cycle clkEn strobes. Monitors serOutValid to
//  flag frames the datapath did not accept. Sits beside the transmitter at top level.
// PARAMETERS
//  STEP_DIV  4        clocks per serial bit; clkEn pulses on the last one (>=2)
//  HEADER    4'b1101  start pattern the sequence detector matches, sent MSB first
//  DATA_W    15       payload register width; max frame length 15 bits
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       asynchronous, active-high reset
//  req0, req1   in   1       frame request, held high until grantN
//  len0, len1   in   4       payload bit count N (0..15), sampled at grant
//  data0, data1 in   DATA_W  payload; bits [N-1:0] sent, bit N-1 first
//  grant0,grant1 out 1       one-cycle pulse: frame latched, source may change
//  done0, done1 out  1       one-cycle pulse: frame fully shifted out
//  err          out  1       one-cycle pulse with doneN when N>0 and serOutValid never seen high
//  serIn        out  1       serial bit to transmitter
//  clkEn        out  1       one-cycle bit strobe to transmitter
//  busy         out  1       high from grant cycle through done cycle
//  serOutValid  in   1       transmitter valid flag, observed only
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, RR pointer favours req0, counters 0.
//  States: IDLE -> HDR -> CNT -> PAY -> FIN -> IDLE.
//   IDLE: if any req, grant per RR pointer; same edge latch len/data into
//     shift regs, pulse grantN, busy=1, go HDR. Pointer moves to the other source.
//     Both req high: pointer picks. No req: stay, serIn=0, clkEn=0.
//   HDR: 4 bits of HEADER; CNT: 4 bits of N, MSB first; PAY: N bits.
//   Each bit = STEP_DIV cycles: serIn set on first cycle, held stable all
//     STEP_DIV cycles, clkEn=1 only on the last cycle; next bit starts next cycle.
//   N=0: CNT goes straight to FIN, PAY skipped.
//   FIN: one cycle after final clkEn; pulse doneN (and err if applicable),
//     busy=0 next cycle, serIn returns 0, return IDLE. New grant earliest the cycle after FIN.
//  Frame length in clocks: (8+N)*STEP_DIV, grant edge to final clkEn inclusive.
//  err tracking: sticky flag cleared at grant, set if serOutValid=1 on any PAY cycle.
//  req dropped before grant: no grant, no frame. req changes during busy: ignored.
//  Bit/step counters wrap only by FSM reload; no free-running wrap effects.
//  Reset mid-frame: immediate abort, outputs 0, no done/err, pointer -> req0.
// TESTING
//  1 req0=1,len0=3,data0=3'b101,STEP_DIV=4 -> grant0 pulse; serIn sequence
//    1,1,0,1,0,0,1,1,1,0,1 each 4 clks; 11 clkEn pulses; done0 44 clks after grant.
//  2 req0&req1 same cycle after reset -> grant0 first, then grant1 after done0;
//    repeat with both high -> order alternates 0,1,0,1.
//  3 len1=0 -> 8 clkEn pulses (1101 0000), done1, err=0.
//  4 len0=5, tie serOutValid=0 -> done0 with err=1; with model driving valid -> err=0.
//  5 assert rst at 6th clkEn of a frame -> outputs 0 async, no done; after release
//    req1 alone granted normally.
//  6 req0 pulsed 1 cycle while busy on source 1 -> no grant0 afterwards.

Source files
------------

// File: rtl/serial_tx_arbiter_if.sv
// Bundles the two requester handshakes and the serial transmitter link so the
// arbiter and its environment connect through one port.
interface serial_tx_arbiter_if #(
    parameter int DATA_W = 15
);
    logic              req0;
    logic              req1;
    logic [3:0]        len0;
    logic [3:0]        len1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              grant0;
    logic              grant1;
    logic              done0;
    logic              done1;
    logic              err;
    logic              serIn;
    logic              clkEn;
    logic              busy;
    logic              serOutValid;

    modport master (
        output req0, req1, len0, len1, data0, data1, serOutValid,
        input  grant0, grant1, done0, done1, err, serIn, clkEn, busy
    );

    modport slave (
        input  req0, req1, len0, len1, data0, data1, serOutValid,
        output grant0, grant1, done0, done1, err, serIn, clkEn, busy
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one serial transmitter between two requesters,
// framing each request as HEADER, 4-bit length and payload with paced clkEn strobes.
module serial_tx_arbiter #(
    parameter int         STEP_DIV = 4,
    parameter logic [3:0] HEADER   = 4'b1101,
    parameter int         DATA_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    serial_tx_arbiter_if.slave bus
);
    localparam int                STEP_W    = $clog2(STEP_DIV);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam int                SH_W      = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, HDR, CNT, PAY, FIN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [STEP_W-1:0] r_step;
    logic [3:0]        r_bit;
    logic [3:0]        r_len;
    logic [DATA_W-1:0] r_shift;
    logic              r_src;
    logic              r_ptr;
    logic              r_valSeen;
    logic              r_grant0;
    logic              r_grant1;

    logic              w_anyReq;
    logic              w_pick;
    logic [3:0]        w_selLen;
    logic [DATA_W-1:0] w_selData;
    logic [SH_W-1:0]   w_shAmt;
    logic              w_sending;
    logic              w_stepLast;
    logic              w_phaseEnd;
    logic              w_serIn;

    // w_pick selects source 1 when high; the pointer only matters on a tie
    assign w_anyReq   = bus.req0 | bus.req1;
    assign w_pick     = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
    assign w_selLen   = w_pick ? bus.len1 : bus.len0;
    assign w_selData  = w_pick ? bus.data1 : bus.data0;
    assign w_shAmt    = SH_W'(DATA_W) - SH_W'(w_selLen);
    assign w_sending  = (r_state == HDR) || (r_state == CNT) || (r_state == PAY);
    assign w_stepLast = (r_step == STEP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_phaseEnd = 1'b0;
        w_serIn    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_next = HDR;
                end
            end
            HDR: begin
                w_serIn = HEADER[2'd3 - r_bit[1:0]];
                if (w_stepLast && (r_bit == 4'd3)) begin
                    w_phaseEnd = 1'b1;
                    w_next     = CNT;
                end
            end
            CNT: begin
                w_serIn = r_len[2'd3 - r_bit[1:0]];
                if (w_stepLast && (r_bit == 4'd3)) begin
                    w_phaseEnd = 1'b1;
                    w_next     = (r_len == 4'd0) ? FIN : PAY;
                end
            end
            PAY: begin
                w_serIn = r_shift[DATA_W-1];
                if (w_stepLast && (r_bit == (r_len - 4'd1))) begin
                    w_phaseEnd = 1'b1;
                    w_next     = FIN;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Payload is left-aligned at grant so bit N-1 leaves first from the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step    <= '0;
            r_bit     <= 4'd0;
            r_len     <= 4'd0;
            r_shift   <= '0;
            r_src     <= 1'b0;
            r_ptr     <= 1'b0;
            r_valSeen <= 1'b0;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
        end else begin
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            if ((r_state == IDLE) && w_anyReq) begin
                r_src     <= w_pick;
                r_ptr     <= ~w_pick;
                r_grant0  <= ~w_pick;
                r_grant1  <= w_pick;
                r_len     <= w_selLen;
                r_shift   <= w_selData << w_shAmt;
                r_step    <= '0;
                r_bit     <= 4'd0;
                r_valSeen <= 1'b0;
            end else if (w_sending) begin
                if ((r_state == PAY) && bus.serOutValid) begin
                    r_valSeen <= 1'b1;
                end
                if (w_stepLast) begin
                    r_step <= '0;
                    r_bit  <= w_phaseEnd ? 4'd0 : (r_bit + 4'd1);
                    if (r_state == PAY) begin
                        r_shift <= r_shift << 1;
                    end
                end else begin
                    r_step <= r_step + STEP_W'(1);
                end
            end
        end
    end

    assign bus.serIn  = w_serIn;
    assign bus.clkEn  = w_sending & w_stepLast;
    assign bus.busy   = (r_state != IDLE);
    assign bus.grant0 = r_grant0;
    assign bus.grant1 = r_grant1;
    assign bus.done0  = (r_state == FIN) & ~r_src;
    assign bus.done1  = (r_state == FIN) & r_src;
    assign bus.err    = (r_state == FIN) && (r_len != 4'd0) && !r_valSeen;
endmodule
